gcd_controller: RTL and testbench
=================================

// Module: gcd_controller
// PURPOSE
//  Sequencing FSM for gcd_datapath: accepts an operand pair on a start/done handshake,
//  owns the working operand registers, drives them onto the datapath A/B inputs,
//  issues subtract/assign strobes from the datapath compare flags, returns the GCD.
//  Adds zero-operand handling, flag sanity checking and an iteration cap.
// PARAMETERS
//  WIDTH     8    operand/result width; matches the datapath
//  MAX_ITER  255  subtraction cap; exceeding it sets err
// PORTS
//  clk           in   1      system clock; all state updates on posedge
//  rst           in   1      synchronous, active-high reset
//  start         in   1      request; sampled only in IDLE
//  a_in, b_in    in   WIDTH  operands, captured on the accepted start cycle
//  busy          out  1      high from the cycle after start is accepted until done
//  done          out  1      one-cycle pulse; result/err valid from this cycle
//  err           out  1      held with result until next accepted start
//  result        out  WIDTH  GCD; held until the next accepted start
//  dp_a, dp_b    out  WIDTH  working registers, driven to datapath A/B
//  AsubB_dp      out  1      one-cycle strobe: a_reg <= a_reg - b_reg this cycle
//  BsubA_dp      out  1      one-cycle strobe: b_reg <= b_reg - a_reg this cycle
//  AssignRes_dp  out  1      one-cycle strobe: result captured this cycle
//  AgtB_dp, BgtA_dp, AeqB_dp  in  1  registered datapath flags, one cycle behind dp_a/dp_b
// BEHAVIOUR
//  Reset: state=IDLE; all outputs, a_reg, b_reg, iter=0. rst mid-operation aborts with no done.
//  States: IDLE, SETTLE, DECIDE, DONE.
//  IDLE:   start=1 -> a_reg<=a_in, b_reg<=b_in, iter<=0, err<=0.
//          a_in==0 & b_in==0: result<=0, err<=1 -> DONE.
//          exactly one zero: result<=nonzero operand, err<=0 -> DONE.
//          both nonzero -> SETTLE.
//  SETTLE: one wait cycle so datapath flags reflect current dp_a/dp_b; -> DECIDE.
//  DECIDE: act on flags, exactly one strobe per cycle.
//    AgtB only: AsubB_dp=1, a_reg<=a_reg-b_reg, iter++, -> SETTLE.
//    BgtA only: BsubA_dp=1, b_reg<=b_reg-a_reg, iter++, -> SETTLE.
//    AeqB only: AssignRes_dp=1, result<=a_reg, -> DONE.
//    zero or more than one flag set: err<=1, result<=0, -> DONE.
//    iter==MAX_ITER with AeqB clear: err<=1, result<=0, -> DONE; no strobe.
//  DONE:   done=1 for one cycle, busy=0, -> IDLE. start in the DONE cycle is ignored.
//  start while busy is ignored; no queuing.
//  Subtraction is unsigned WIDTH-bit; underflow cannot occur because strobes follow flags.
//  iter is ceil(log2(MAX_ITER+1)) bits and saturates.
//  Latency (start accepted at cycle 0, N subtractions): done at cycle 2N+3.
//  Zero-operand case: done at cycle 1.
//  busy is high during SETTLE/DECIDE only.
// STRUCTURE
//  gcd_defs.vh: state encodings (2-bit), WIDTH default, flag-check macro.
//  Shared by the controller and its bench.
//  One sub-module, gcd_iter_counter: clear/increment/saturate and hit-cap compare on MAX_ITER.
//  The FSM and operand registers stay flat in gcd_controller.
//  Top wiring: dp_a/dp_b -> gcd_datapath A/B; strobes and flags connect one-to-one.
// TESTING
//  1 (12,8): strobe trace AsubB, BsubA, AssignRes -> result=4, err=0, done at cycle 7.
//  2 (7,7): AssignRes at first DECIDE -> result=7, done at cycle 3.
//  3 (255,1): with MAX_ITER=255 -> 254 AsubB, result=1.
//     With MAX_ITER=100 -> err=1, result=0, done at cycle 203.
//  4a (0,9) -> result=9, err=0, done at cycle 1.
//  4b (0,0) -> result=0, err=1, done at cycle 1.
//  5 Start pulses during busy are ignored. Second start on the done cycle is ignored.
//     Start on the cycle after done is accepted with the new operands.
//  6 rst in DECIDE mid-run -> next cycle all outputs 0, state IDLE, no done.
//     Forced flag pairs AgtB=BgtA=1 or all-zero in DECIDE -> err=1, done next cycle.

Source files
------------

// File: rtl/gcd_controller_pkg.sv
// rtl/gcd_controller_pkg.sv - shared state/flag encodings and defaults for the GCD controller
package gcd_controller_pkg;

   localparam int DEF_WIDTH    = 8;
   localparam int DEF_MAX_ITER = 255;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETTLE = 2'd1,
      ST_DECIDE = 2'd2,
      ST_DONE   = 2'd3
   } gcd_state_t;

   typedef enum logic [1:0] {
      FL_AGTB = 2'd0,
      FL_BGTA = 2'd1,
      FL_AEQB = 2'd2,
      FL_BAD  = 2'd3
   } gcd_flag_t;

   // Anything other than exactly one asserted compare flag is a datapath fault.
   function automatic gcd_flag_t decode_flags(input logic agtb, input logic bgta, input logic aeqb);
      case ({agtb, bgta, aeqb})
         3'b100:  return FL_AGTB;
         3'b010:  return FL_BGTA;
         3'b001:  return FL_AEQB;
         default: return FL_BAD;
      endcase
   endfunction

endpackage

// File: rtl/gcd_iter_counter.sv
// rtl/gcd_iter_counter.sv - saturating subtraction counter with cap-reached compare
module gcd_iter_counter #(
   parameter int MAX_ITER = 255,
   parameter int CW       = (MAX_ITER < 1) ? 1 : $clog2(MAX_ITER + 1)
) (
   input  logic clk,
   input  logic rst,
   input  logic i_clr,
   input  logic i_inc,
   output logic o_hit
);

   localparam logic [CW-1:0] CAP = CW'(MAX_ITER);

   logic [CW-1:0] r_count;

   always_ff @(posedge clk) begin
      if (rst || i_clr) begin
         r_count <= '0;
      end else if (i_inc && (r_count != CAP)) begin
         r_count <= r_count + CW'(1);
      end
   end

   assign o_hit = (r_count == CAP);

endmodule

// File: rtl/gcd_controller.sv
// rtl/gcd_controller.sv - subtract-and-compare GCD sequencer driving an external datapath
module gcd_controller
   import gcd_controller_pkg::*;
#(
   parameter int WIDTH    = DEF_WIDTH,
   parameter int MAX_ITER = DEF_MAX_ITER
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a_in,
   input  logic [WIDTH-1:0] b_in,
   output logic             busy,
   output logic             done,
   output logic             err,
   output logic [WIDTH-1:0] result,
   output logic [WIDTH-1:0] dp_a,
   output logic [WIDTH-1:0] dp_b,
   output logic             AsubB_dp,
   output logic             BsubA_dp,
   output logic             AssignRes_dp,
   input  logic             AgtB_dp,
   input  logic             BgtA_dp,
   input  logic             AeqB_dp
);

   gcd_state_t       r_state;
   gcd_state_t       w_next_state;
   gcd_flag_t        w_flags;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic [WIDTH-1:0] r_result;
   logic             r_err;
   logic             w_clr;
   logic             w_inc;
   logic             w_fail;
   logic             w_hit;

   gcd_iter_counter #(.MAX_ITER(MAX_ITER)) u_iter (
      .clk   (clk),
      .rst   (rst),
      .i_clr (w_clr),
      .i_inc (w_inc),
      .o_hit (w_hit)
   );

   assign w_flags = decode_flags(AgtB_dp, BgtA_dp, AeqB_dp);

   always_comb begin
      w_next_state = r_state;
      w_clr        = 1'b0;
      w_inc        = 1'b0;
      w_fail       = 1'b0;
      AsubB_dp     = 1'b0;
      BsubA_dp     = 1'b0;
      AssignRes_dp = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (start) begin
               w_clr        = 1'b1;
               w_next_state = (a_in == '0 || b_in == '0) ? ST_DONE : ST_SETTLE;
            end
         end
         ST_SETTLE: w_next_state = ST_DECIDE;
         ST_DECIDE: begin
            // Cap check wins unless this very cycle is the final equal compare.
            if (w_hit && !AeqB_dp) begin
               w_fail       = 1'b1;
               w_next_state = ST_DONE;
            end else begin
               case (w_flags)
                  FL_AGTB: begin
                     AsubB_dp     = 1'b1;
                     w_inc        = 1'b1;
                     w_next_state = ST_SETTLE;
                  end
                  FL_BGTA: begin
                     BsubA_dp     = 1'b1;
                     w_inc        = 1'b1;
                     w_next_state = ST_SETTLE;
                  end
                  FL_AEQB: begin
                     AssignRes_dp = 1'b1;
                     w_next_state = ST_DONE;
                  end
                  default: begin
                     w_fail       = 1'b1;
                     w_next_state = ST_DONE;
                  end
               endcase
            end
         end
         ST_DONE: w_next_state = ST_IDLE;
         default: w_next_state = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state  <= ST_IDLE;
         r_a      <= '0;
         r_b      <= '0;
         r_result <= '0;
         r_err    <= 1'b0;
      end else begin
         r_state <= w_next_state;
         if (w_clr) begin
            r_a      <= a_in;
            r_b      <= b_in;
            r_err    <= (a_in == '0 && b_in == '0);
            r_result <= (a_in == '0) ? b_in : ((b_in == '0) ? a_in : '0);
         end
         if (AsubB_dp)     r_a      <= r_a - r_b;
         if (BsubA_dp)     r_b      <= r_b - r_a;
         if (AssignRes_dp) r_result <= r_a;
         if (w_fail) begin
            r_err    <= 1'b1;
            r_result <= '0;
         end
      end
   end

   assign busy   = (r_state == ST_SETTLE) || (r_state == ST_DECIDE);
   assign done   = (r_state == ST_DONE);
   assign err    = r_err;
   assign result = r_result;
   assign dp_a   = r_a;
   assign dp_b   = r_b;

endmodule

// File: tb/tb_gcd_controller.sv
// tb/tb_gcd_controller.sv - randomized and directed bench for gcd_controller with a datapath flag model
module tb_gcd_controller;

   logic       clk = 1'b0;
   logic       rst;
   logic       start0, start1;
   logic [7:0] a_in, b_in;
   logic       busy0, done0, err0, asub0, bsub0, asg0, agtb0, bgta0, aeqb0;
   logic       busy1, done1, err1, asub1, bsub1, asg1, agtb1, bgta1, aeqb1;
   logic [7:0] res0, dpa0, dpb0, res1, dpa1, dpb1;
   logic       force_en;
   logic [2:0] force_val;
   int         total = 0;
   int         bad = 0;

   always #5 clk = ~clk;

   gcd_controller dut0 (
      .clk(clk), .rst(rst), .start(start0), .a_in(a_in), .b_in(b_in),
      .busy(busy0), .done(done0), .err(err0), .result(res0), .dp_a(dpa0), .dp_b(dpb0),
      .AsubB_dp(asub0), .BsubA_dp(bsub0), .AssignRes_dp(asg0),
      .AgtB_dp(agtb0), .BgtA_dp(bgta0), .AeqB_dp(aeqb0)
   );

   gcd_controller #(.MAX_ITER(100)) dut1 (
      .clk(clk), .rst(rst), .start(start1), .a_in(a_in), .b_in(b_in),
      .busy(busy1), .done(done1), .err(err1), .result(res1), .dp_a(dpa1), .dp_b(dpb1),
      .AsubB_dp(asub1), .BsubA_dp(bsub1), .AssignRes_dp(asg1),
      .AgtB_dp(agtb1), .BgtA_dp(bgta1), .AeqB_dp(aeqb1)
   );

   // Datapath stand-in: compare flags registered one cycle behind dp_a/dp_b.
   always @(posedge clk) begin
      if (force_en) {agtb0, bgta0, aeqb0} <= force_val;
      else          {agtb0, bgta0, aeqb0} <= {dpa0 > dpb0, dpb0 > dpa0, dpa0 == dpb0};
      {agtb1, bgta1, aeqb1} <= {dpa1 > dpb1, dpb1 > dpa1, dpa1 == dpb1};
   end

   function automatic void model(input int a, input int b, input int mx, output int lat,
                                 output int res, output bit e, output int na, output int nb);
      int n;
      na = 0; nb = 0; e = 1'b0; n = 0;
      if (a == 0 && b == 0) begin
         res = 0; e = 1'b1; lat = 1;
      end else if (a == 0 || b == 0) begin
         res = a + b; lat = 1;
      end else begin
         while (a != b && !e) begin
            if (n == mx) e = 1'b1;
            else begin
               if (a > b) begin a = a - b; na++; end
               else       begin b = b - a; nb++; end
               n++;
            end
         end
         res = e ? 0 : a;
         lat = 2 * n + 3;
      end
   endfunction

   task automatic drive_op(input logic [7:0] a, input logic [7:0] b, input bit use1,
                           output int lat, output logic [7:0] res, output logic e,
                           output int na, output int nb, output bit viol, output logic [15:0] trace);
      logic bz, dn, s_a, s_b, s_r;
      lat = -1; na = 0; nb = 0; viol = 1'b0; trace = '0; res = '0; e = 1'b0;
      @(negedge clk);
      a_in = a; b_in = b;
      if (use1) start1 = 1'b1; else start0 = 1'b1;
      @(posedge clk);
      #1 start0 = 1'b0; start1 = 1'b0;
      for (int k = 1; k <= 2000; k++) begin
         @(negedge clk);
         bz  = use1 ? busy1 : busy0;
         dn  = use1 ? done1 : done0;
         s_a = use1 ? asub1 : asub0;
         s_b = use1 ? bsub1 : bsub0;
         s_r = use1 ? asg1  : asg0;
         if ((32'(s_a) + 32'(s_b) + 32'(s_r)) > 1) viol = 1'b1;
         if ((s_a || s_b || s_r) && !bz) viol = 1'b1;
         if (dn == bz) viol = 1'b1;
         if (s_a) begin na++; trace = {trace[13:0], 2'd1}; end
         if (s_b) begin nb++; trace = {trace[13:0], 2'd2}; end
         if (s_r) trace = {trace[13:0], 2'd3};
         if (dn) begin
            lat = k;
            res = use1 ? res1 : res0;
            e   = use1 ? err1 : err0;
            break;
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      total++;
      if ({busy0, done0, err0, res0, dpa0, dpb0, asub0, bsub0, asg0} !== 31'd0) begin
         bad++; $display("FAIL reset_dut0: got %h want 0", {busy0, done0, err0, res0, dpa0, dpb0, asub0, bsub0, asg0});
      end
      total++;
      if ({busy1, done1, err1, res1, dpa1, dpb1} !== 27'd0) begin
         bad++; $display("FAIL reset_dut1: got %h want 0", {busy1, done1, err1, res1, dpa1, dpb1});
      end
      rst = 1'b0;
   endtask

   task automatic test_directed();
      int lat, na, nb; logic [7:0] r; logic e; bit v; logic [15:0] tr;
      drive_op(8'd12, 8'd8, 1'b0, lat, r, e, na, nb, v, tr);
      total++;
      if (r !== 8'd4 || e !== 1'b0 || lat != 7) begin
         bad++; $display("FAIL gcd_12_8: got r=%0d e=%0b lat=%0d want r=4 e=0 lat=7", r, e, lat);
      end
      total++;
      if (tr !== 16'h001B || v) begin
         bad++; $display("FAIL trace_12_8: got %h viol=%0b want 001b viol=0", tr, v);
      end
      @(negedge clk);
      total++;
      if (res0 !== 8'd4 || done0 !== 1'b0) begin
         bad++; $display("FAIL hold_12_8: got r=%0d done=%0b want r=4 done=0", res0, done0);
      end
      drive_op(8'd7, 8'd7, 1'b0, lat, r, e, na, nb, v, tr);
      total++;
      if (r !== 8'd7 || e !== 1'b0 || lat != 3 || tr !== 16'h0003) begin
         bad++; $display("FAIL gcd_7_7: got r=%0d e=%0b lat=%0d tr=%h want r=7 e=0 lat=3 tr=0003", r, e, lat, tr);
      end
   endtask

   task automatic test_cap();
      int lat, na, nb; logic [7:0] r; logic e; bit v; logic [15:0] tr;
      drive_op(8'd255, 8'd1, 1'b0, lat, r, e, na, nb, v, tr);
      total++;
      if (r !== 8'd1 || e !== 1'b0 || na != 254 || nb != 0 || lat != 511) begin
         bad++; $display("FAIL cap255: got r=%0d e=%0b na=%0d nb=%0d lat=%0d want r=1 e=0 na=254 nb=0 lat=511", r, e, na, nb, lat);
      end
      drive_op(8'd255, 8'd1, 1'b1, lat, r, e, na, nb, v, tr);
      total++;
      if (r !== 8'd0 || e !== 1'b1 || na != 100 || lat != 203) begin
         bad++; $display("FAIL cap100: got r=%0d e=%0b na=%0d lat=%0d want r=0 e=1 na=100 lat=203", r, e, na, lat);
      end
   endtask

   task automatic test_zero();
      int lat, na, nb; logic [7:0] r; logic e; bit v; logic [15:0] tr;
      logic [7:0] za [3] = '{8'd0, 8'd9, 8'd0};
      logic [7:0] zb [3] = '{8'd9, 8'd0, 8'd0};
      logic [7:0] zr [3] = '{8'd9, 8'd9, 8'd0};
      logic       ze [3] = '{1'b0, 1'b0, 1'b1};
      for (int i = 0; i < 3; i++) begin
         drive_op(za[i], zb[i], 1'b0, lat, r, e, na, nb, v, tr);
         total++;
         if (r !== zr[i] || e !== ze[i] || lat != 1 || tr !== 16'h0) begin
            bad++; $display("FAIL zero_%0d_%0d: got r=%0d e=%0b lat=%0d want r=%0d e=%0b lat=1", za[i], zb[i], r, e, lat, zr[i], ze[i]);
         end
      end
   endtask

   task automatic test_random();
      int lat, na, nb, mlat, mres, mna, mnb, a, b; logic [7:0] r; logic e; bit v, me; logic [15:0] tr;
      for (int i = 0; i < 24; i++) begin
         case ($urandom_range(0, 3))
            0:       begin a = $urandom_range(1, 15);  b = $urandom_range(1, 15); end
            1:       begin a = $urandom_range(0, 255); b = 0; end
            default: begin a = $urandom_range(1, 255); b = $urandom_range(1, 255); end
         endcase
         if ($urandom_range(0, 1) == 1) begin int t = a; a = b; b = t; end
         model(a, b, 255, mlat, mres, me, mna, mnb);
         drive_op(a[7:0], b[7:0], 1'b0, lat, r, e, na, nb, v, tr);
         total++;
         if (32'(r) != mres || e !== me || lat != mlat) begin
            bad++; $display("FAIL rand_%0d_%0d: got r=%0d e=%0b lat=%0d want r=%0d e=%0b lat=%0d", a, b, r, e, lat, mres, me, mlat);
         end
         total++;
         if (na != mna || nb != mnb || v) begin
            bad++; $display("FAIL rand_strobes_%0d_%0d: got na=%0d nb=%0d viol=%0b want na=%0d nb=%0d viol=0", a, b, na, nb, v, mna, mnb);
         end
      end
   endtask

   task automatic test_busy_start();
      int lat;
      @(negedge clk);
      a_in = 8'd12; b_in = 8'd8; start0 = 1'b1;
      @(posedge clk);
      #1 a_in = 8'd0; b_in = 8'd5;
      lat = -1;
      for (int k = 1; k <= 50; k++) begin
         @(negedge clk);
         if (done0) begin lat = k; break; end
      end
      total++;
      if (lat != 7 || res0 !== 8'd4) begin
         bad++; $display("FAIL busy_ignore: got lat=%0d r=%0d want lat=7 r=4", lat, res0);
      end
      @(posedge clk);
      #1 a_in = 8'd9; b_in = 8'd6;
      @(negedge clk);
      total++;
      if (done0 !== 1'b0 || busy0 !== 1'b0) begin
         bad++; $display("FAIL done_cycle_start: got done=%0b busy=%0b want 0 0", done0, busy0);
      end
      @(posedge clk);
      #1 start0 = 1'b0;
      lat = -1;
      for (int k = 1; k <= 50; k++) begin
         @(negedge clk);
         if (done0) begin lat = k; break; end
      end
      total++;
      if (lat != 7 || res0 !== 8'd3 || err0 !== 1'b0) begin
         bad++; $display("FAIL after_done_start: got lat=%0d r=%0d e=%0b want lat=7 r=3 e=0", lat, res0, err0);
      end
   endtask

   task automatic test_reset_mid();
      int lat, na, nb; logic [7:0] r; logic e; bit v, seen, dn; logic [15:0] tr;
      @(negedge clk);
      a_in = 8'd200; b_in = 8'd3; start0 = 1'b1;
      @(posedge clk);
      #1 start0 = 1'b0;
      seen = 1'b0;
      for (int k = 0; k < 40 && !seen; k++) begin
         @(negedge clk);
         if (asub0 && k > 6) seen = 1'b1;
      end
      total++;
      if (!seen) begin bad++; $display("FAIL mid_reach_decide: got 0 want 1"); end
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      total++;
      if ({busy0, done0, err0, res0, dpa0, dpb0, asub0, bsub0, asg0} !== 31'd0) begin
         bad++; $display("FAIL mid_reset: got %h want 0", {busy0, done0, err0, res0, dpa0, dpb0, asub0, bsub0, asg0});
      end
      dn = 1'b0;
      repeat (10) begin
         @(negedge clk);
         dn = dn | done0 | busy0;
      end
      total++;
      if (dn !== 1'b0) begin bad++; $display("FAIL mid_no_done: got %0b want 0", dn); end
      drive_op(8'd12, 8'd8, 1'b0, lat, r, e, na, nb, v, tr);
      total++;
      if (r !== 8'd4 || lat != 7) begin
         bad++; $display("FAIL mid_recover: got r=%0d lat=%0d want r=4 lat=7", r, lat);
      end
   endtask

   task automatic test_bad_flags();
      int lat, na, nb; logic [7:0] r; logic e; bit v; logic [15:0] tr;
      logic [2:0] fv [3] = '{3'b110, 3'b000, 3'b011};
      for (int i = 0; i < 3; i++) begin
         force_en = 1'b1; force_val = fv[i];
         drive_op(8'd12, 8'd8, 1'b0, lat, r, e, na, nb, v, tr);
         force_en = 1'b0;
         total++;
         if (r !== 8'd0 || e !== 1'b1 || lat != 3 || tr !== 16'h0 || v) begin
            bad++; $display("FAIL bad_flags_%b: got r=%0d e=%0b lat=%0d tr=%h viol=%0b want r=0 e=1 lat=3 tr=0 viol=0", fv[i], r, e, lat, tr, v);
         end
      end
   endtask

   initial begin
      rst = 1'b1; start0 = 1'b0; start1 = 1'b0; a_in = '0; b_in = '0;
      force_en = 1'b0; force_val = '0;
      test_reset();
      test_directed();
      test_cap();
      test_zero();
      test_random();
      test_busy_start();
      test_reset_mid();
      test_bad_flags();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
